// File: rtl/uart_rx_tof_decoder.sv
// rtl/uart_rx_tof_decoder.sv - 8N1 UART receiver with 5-byte TOF frame parser
// Recovers the 20-bit echo time-of-flight from FA/TH/TM/TL/FB frames.
module uart_rx_tof_decoder #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        rs232_rx,
  output logic [19:0] echo_tof,
  output logic        tof_valid,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int TO_CYC   = TIMEOUT_BITS * BIT_CYC;
  localparam int BW       = $clog2(BIT_CYC);
  localparam int TW       = $clog2(TO_CYC);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [2:0] {F_HDR, F_TH, F_TM, F_TL, F_TAIL} frame_state_t;

  bit_state_t   b_state, b_next;
  frame_state_t f_state, f_next;

  logic          rx_meta, rx_s, rx_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic [19:0]   tof_acc, acc_next;
  logic          cnt_clr, bit_tick, byte_done, byte_err;
  logic          timeout, err_set, valid_set;

  // rx_d trails the synchronised level by one cycle for falling-edge detection
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_comb begin
    b_next    = b_state;
    cnt_clr   = 1'b0;
    bit_tick  = 1'b0;
    byte_done = 1'b0;
    byte_err  = 1'b0;
    case (b_state)
      B_IDLE: begin
        if (rx_d && !rx_s) begin
          cnt_clr = 1'b1;
          b_next  = B_START;
        end
      end
      B_START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          b_next  = rx_s ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          bit_tick = 1'b1;
          if (bit_idx == 3'd7) b_next = B_STOP;
        end
      end
      B_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed
        if (baud_cnt == BIT_LAST) begin
          cnt_clr   = 1'b1;
          byte_done = rx_s;
          byte_err  = !rx_s;
          b_next    = B_IDLE;
        end
      end
      default: b_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      b_state  <= B_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      b_state  <= b_next;
      baud_cnt <= cnt_clr ? '0 : baud_cnt + 1'b1;
      if (bit_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign timeout = (b_state == B_IDLE) && (f_state != F_HDR) && (to_cnt == TO_LAST);

  always_comb begin
    f_next    = f_state;
    acc_next  = tof_acc;
    err_set   = 1'b0;
    valid_set = 1'b0;
    if (timeout) begin
      f_next  = F_HDR;
      err_set = 1'b1;
    end else if (byte_err) begin
      // Noise before a header is not an error
      if (f_state != F_HDR) begin
        f_next  = F_HDR;
        err_set = 1'b1;
      end
    end else if (byte_done) begin
      case (f_state)
        F_HDR: if (shreg == 8'hFA) f_next = F_TH;
        F_TH: begin
          if (shreg[7:4] != 4'h0) begin
            f_next  = F_HDR;
            err_set = 1'b1;
          end else begin
            acc_next[19:16] = shreg[3:0];
            f_next          = F_TM;
          end
        end
        F_TM: begin
          acc_next[15:8] = shreg;
          f_next         = F_TL;
        end
        F_TL: begin
          acc_next[7:0] = shreg;
          f_next        = F_TAIL;
        end
        F_TAIL: begin
          f_next    = F_HDR;
          valid_set = (shreg == 8'hFB);
          err_set   = (shreg != 8'hFB);
        end
        default: f_next = F_HDR;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      f_state   <= F_HDR;
      tof_acc   <= 20'h0;
      echo_tof  <= 20'h0;
      tof_valid <= 1'b0;
      frame_err <= 1'b0;
      to_cnt    <= '0;
    end else begin
      f_state   <= f_next;
      tof_acc   <= acc_next;
      tof_valid <= valid_set;
      frame_err <= err_set;
      if (valid_set) echo_tof <= tof_acc;
      if ((b_state == B_IDLE) && (f_state != F_HDR) && !timeout) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
    end
  end

  assign rx_busy = (b_state != B_IDLE) || (f_state != F_HDR);

endmodule

// File: tb/tb_uart_rx_tof_decoder.sv
// tb/tb_uart_rx_tof_decoder.sv - directed and randomized frame bench with a byte-level frame model
// Runs the DUT at 16 clocks per bit so the whole run stays short.
module tb_uart_rx_tof_decoder;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115200;
  localparam int TOB      = 20;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        rs232_rx = 1'b1;
  logic [19:0] echo_tof;
  logic        tof_valid, frame_err, rx_busy;

  uart_rx_tof_decoder #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .echo_tof (echo_tof),
    .tof_valid(tof_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  typedef struct packed {
    logic        is_err;
    logic [19:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  frame_q[$];
  logic [19:0] exp_echo = 20'h0;
  int total = 0, passed = 0;
  int n_valid = 0, n_err = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, last_stop_cyc = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Frame model: a queue of bytes collected since a header was seen
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [19:0] v;
    if (!stop_ok) begin
      if (frame_q.size() != 0) begin
        exp_q.push_back({1'b1, 20'h0});
        frame_q.delete();
      end
    end else if (frame_q.size() == 0) begin
      if (b == 8'hFA) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 2 && b[7:4] != 4'h0) begin
        exp_q.push_back({1'b1, 20'h0});
        frame_q.delete();
      end else if (frame_q.size() == 5) begin
        v = {frame_q[1][3:0], frame_q[2], frame_q[3]};
        if (b == 8'hFB) exp_q.push_back({1'b0, v});
        else exp_q.push_back({1'b1, 20'h0});
        frame_q.delete();
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    int g;
    g = gap;
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    last_stop_cyc = cyc;
    model_byte(b, stop_ok);
    hold(stop_ok, BIT);
    if (!stop_ok && g < BIT) g = BIT;
    if (g > 0) hold(1'b1, g);
  endtask

  // Only called with gaps well below or well above the timeout
  task automatic idle_gap(input int n);
    if (n >= 25 * BIT && frame_q.size() != 0) begin
      exp_q.push_back({1'b1, 20'h0});
      frame_q.delete();
    end
    hold(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int bad_idx);
    logic [7:0] fb[5];
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
    for (int i = 0; i < 5; i++) send_byte(fb[i], i != bad_idx, $urandom_range(0, BIT / 2));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(posedge clk_50M);
    #1;
    chk(exp_q.size() == 0, "expected_pulse_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic compare_step();
    exp_t e;
    if (!rst_n) begin
      exp_echo = 20'h0;
      chk({tof_valid, frame_err, rx_busy} == 3'b000 && echo_tof == 20'h0, "reset_outputs",
          {9'h0, tof_valid, frame_err, rx_busy, echo_tof}, 32'h0);
    end else begin
      chk(!(tof_valid && frame_err), "valid_err_exclusive", {30'h0, tof_valid, frame_err}, 32'h0);
      if (tof_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", {30'h0, tof_valid, frame_err}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(e.is_err == frame_err, "pulse_kind", {31'h0, frame_err}, {31'h0, e.is_err});
          if (tof_valid) begin
            chk(echo_tof == e.val, "tof_value", {12'h0, echo_tof}, {12'h0, e.val});
            exp_echo = e.val;
            n_valid++;
            last_valid_cyc = cyc;
          end else begin
            n_err++;
            last_err_cyc = cyc;
          end
        end
      end else begin
        chk(echo_tof == exp_echo, "echo_hold", {12'h0, echo_tof}, {12'h0, exp_echo});
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    int v0, e0, kind, k, bad;
    logic [19:0] v;
    logic [7:0]  tb;
    fork
      forever begin
        @(negedge clk_50M);
        compare_step();
      end
    join_none

    repeat (4) @(posedge clk_50M);
    #1;
    chk(echo_tof == 20'h0 && !tof_valid && !frame_err && !rx_busy, "reset_state",
        {9'h0, tof_valid, frame_err, rx_busy, echo_tof}, 32'h0);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT);

    // 1: plain frame, including latency from start of stop bit (half bit + 3 sync/edge clocks)
    v0 = n_valid;
    send_frame(8'hFA, 8'h00, 8'h12, 8'h34, 8'hFB, -1);
    drain();
    chk(echo_tof == 20'h01234, "t1_echo", {12'h0, echo_tof}, 32'h01234);
    chk(n_valid == v0 + 1, "t1_valid_count", 32'(n_valid - v0), 32'd1);
    chk(last_valid_cyc - last_stop_cyc >= 9 && last_valid_cyc - last_stop_cyc <= 13, "t1_latency",
        32'(last_valid_cyc - last_stop_cyc), 32'd11);

    // 2: leading junk ignored
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'hAA, 1'b1, 0);
    send_frame(8'hFA, 8'h0F, 8'hFF, 8'hFF, 8'hFB, -1);
    drain();
    chk(echo_tof == 20'hFFFFF, "t2_echo", {12'h0, echo_tof}, 32'hFFFFF);

    // 3: bad TH nibble errors right after byte 2
    e0 = n_err; v0 = n_valid;
    send_byte(8'hFA, 1'b1, 0);
    send_byte(8'h10, 1'b1, 0);
    chk(n_err == e0 + 1, "t3_err_after_th", 32'(n_err - e0), 32'd1);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'hFB, 1'b1, 0);
    drain();
    chk(n_valid == v0 && echo_tof == 20'hFFFFF, "t3_echo_kept", {12'h0, echo_tof}, 32'hFFFFF);

    // 4: stop-bit error on the tail, then a good frame
    e0 = n_err;
    send_frame(8'hFA, 8'h00, 8'h00, 8'h05, 8'hFB, 4);
    drain();
    chk(n_err == e0 + 1, "t4_err_count", 32'(n_err - e0), 32'd1);
    send_frame(8'hFA, 8'h00, 8'h00, 8'h07, 8'hFB, -1);
    drain();
    chk(echo_tof == 20'h00007, "t4_echo", {12'h0, echo_tof}, 32'h7);

    // 5: inter-byte timeout at 20 bit times after the mid-stop sample
    send_byte(8'hFA, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    chk(rx_busy == 1'b1, "t5_busy_mid_frame", {31'h0, rx_busy}, 32'h1);
    e0 = n_err;
    idle_gap(25 * BIT);
    chk(n_err == e0 + 1, "t5_timeout_err", 32'(n_err - e0), 32'd1);
    chk(last_err_cyc - last_stop_cyc >= 329 && last_err_cyc - last_stop_cyc <= 333, "t5_timeout_time",
        32'(last_err_cyc - last_stop_cyc), 32'd331);
    chk(rx_busy == 1'b0, "t5_busy_low", {31'h0, rx_busy}, 32'h0);
    send_frame(8'hFA, 8'h00, 8'h00, 8'h09, 8'hFB, -1);
    drain();
    chk(echo_tof == 20'h00009, "t5_echo", {12'h0, echo_tof}, 32'h9);

    // 6: short low glitch on idle, then reset mid-frame
    e0 = n_err; v0 = n_valid;
    hold(1'b0, BIT / 4);
    hold(1'b1, 3 * BIT);
    chk(n_err == e0 && n_valid == v0 && rx_busy == 1'b0, "t6_glitch_ignored",
        32'(n_err - e0 + n_valid - v0), 32'd0);
    send_byte(8'hFA, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    rst_n = 1'b0;
    frame_q.delete();
    exp_q.delete();
    exp_echo = 20'h0;
    repeat (3) @(posedge clk_50M);
    #1;
    chk(echo_tof == 20'h0 && !rx_busy && !tof_valid && !frame_err, "t6_reset_mid_frame",
        {9'h0, tof_valid, frame_err, rx_busy, echo_tof}, 32'h0);
    rst_n = 1'b1;
    hold(1'b1, BIT);
    send_frame(8'hFA, 8'h00, 8'hAB, 8'hCD, 8'hFB, -1);
    drain();
    chk(echo_tof == 20'h0ABCD, "t6_after_reset", {12'h0, echo_tof}, 32'h0ABCD);

    // Randomized frames against the model
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      v = 20'($urandom);
      tb = 8'($urandom);
      if (tb == 8'hFB) tb = 8'hFC;
      case (kind)
        0: send_frame(8'hFA, {4'h0, v[19:16]}, v[15:8], v[7:0], 8'hFB, -1);
        1: send_frame(8'hFA, {4'($urandom_range(1, 15)), v[19:16]}, v[15:8], v[7:0], 8'hFB, -1);
        2: send_frame(8'hFA, {4'h0, v[19:16]}, v[15:8], v[7:0], tb, -1);
        3: begin
          bad = $urandom_range(1, 4);
          send_frame(8'hFA, {4'h0, v[19:16]}, v[15:8], v[7:0], 8'hFB, bad);
        end
        4: begin
          k = $urandom_range(1, 3);
          for (int j = 0; j < k; j++) send_byte(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, BIT));
          send_frame(8'hFA, {4'h0, v[19:16]}, v[15:8], v[7:0], 8'hFB, -1);
        end
        default: begin
          k = $urandom_range(0, 3);
          send_byte(8'hFA, 1'b1, 0);
          for (int j = 0; j < k; j++) send_byte(8'h00, 1'b1, $urandom_range(0, BIT));
          idle_gap(25 * BIT + $urandom_range(0, 4 * BIT));
        end
      endcase
      idle_gap($urandom_range(0, 2 * BIT));
      drain();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
